// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset/halt addresses and jump-selection encodings.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] HALT_ADDR            = 32'h0000_0000;

  typedef enum logic [1:0] {
    JSEL_NONE = 2'b00,
    JSEL_ABS  = 2'b01,
    JSEL_PAGE = 2'b10,
    JSEL_REL  = 2'b11
  } jump_sel_e;

  // Candidate transfer targets captured from one instruction
  typedef struct packed {
    logic [XLEN-1:0] abs_t;
    logic [XLEN-1:0] page_t;
    logic [XLEN-1:0] rel_t;
  } pc_targets_t;

endpackage

// File: rtl/pc_update_if.sv
// Execute-stage bus between the sequencer/branch logic and the PC update block.
interface pc_update_if;
  logic        state;
  logic        stall;
  logic [1:0]  jump_addr_selection;
  logic [31:0] instruction_word;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        in_delay_slot;
  logic        active;

  modport master (
    output state, stall, jump_addr_selection, instruction_word, rs_data,
    input  pc, pc_plus8, in_delay_slot, active
  );

  modport slave (
    input  state, stall, jump_addr_selection, instruction_word, rs_data,
    output pc, pc_plus8, in_delay_slot, active
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational target arithmetic: sequential, absolute, page-absolute and PC-relative.
module pc_target_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction_word,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] pc_plus8_c,
  output pc_targets_t     targets_c
);

  logic [XLEN-1:0] branch_off;
  logic            unused_opcode;

  always_comb begin
    pc_plus4_c       = pc + XLEN'(4);
    pc_plus8_c       = pc + XLEN'(8);
    // Word offset: sign-extend imm16 and scale by 4
    branch_off       = {{(XLEN-18){instruction_word[15]}}, instruction_word[15:0], 2'b00};
    targets_c.abs_t  = rs_data;
    targets_c.page_t = {pc_plus4_c[XLEN-1:XLEN-4], instruction_word[25:0], 2'b00};
    targets_c.rel_t  = pc_plus4_c + branch_off;
  end

  assign unused_opcode = ^instruction_word[XLEN-1:26];

endmodule

// File: rtl/pc_update.sv
// Program counter with one-instruction delay slot, delay-slot transfer suppression and halt-at-zero.
module pc_update
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  pc_update_if.slave  bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            active_q, active_d;
  logic            ignore_q, ignore_d;
  pc_targets_t     tgt_q, tgt_d, tgt_c;

  jump_sel_e       sel;
  logic            update_c;
  logic            take_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] pc_plus8_c;
  logic [XLEN-1:0] target_c;

  pc_target_calc u_calc (
    .pc               (pc_q),
    .instruction_word (bus.instruction_word),
    .rs_data          (bus.rs_data),
    .pc_plus4_c       (pc_plus4_c),
    .pc_plus8_c       (pc_plus8_c),
    .targets_c        (tgt_c)
  );

  assign sel = jump_sel_e'(bus.jump_addr_selection);

  // Next-state: targets captured now are consumed at the following update (the delay slot's)
  always_comb begin
    pc_d     = pc_q;
    active_d = active_q;
    ignore_d = ignore_q;
    tgt_d    = tgt_q;
    target_c = pc_plus4_c;
    update_c = bus.state && !bus.stall && active_q;
    take_c   = (sel != JSEL_NONE) && !ignore_q;

    unique case (sel)
      JSEL_ABS:  target_c = tgt_q.abs_t;
      JSEL_PAGE: target_c = tgt_q.page_t;
      JSEL_REL:  target_c = tgt_q.rel_t;
      default:   target_c = pc_plus4_c;
    endcase

    if (update_c) begin
      tgt_d    = tgt_c;
      ignore_d = take_c;
      pc_d     = take_c ? target_c : pc_plus4_c;
      if (pc_d == HALT_ADDR) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VECTOR;
      active_q <= 1'b1;
      ignore_q <= 1'b0;
      tgt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      active_q <= active_d;
      ignore_q <= ignore_d;
      tgt_q    <= tgt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus8      = pc_plus8_c;
  assign bus.in_delay_slot = take_c;
  assign bus.active        = active_q;

endmodule

// File: tb/tb_pc_update.sv
// Randomized instruction-stream bench for pc_update against an instruction-level PC model.
module tb_pc_update;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  // Instruction-level model state
  logic [31:0] m_pc = RV;
  logic        m_active = 1'b1;
  logic        m_ds = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [1:0]  prev_kind = 2'd0;

  pc_update_if bus ();

  pc_update #(.RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] target_of(input logic [1:0] kind, input logic [31:0] iw,
                                            input logic [31:0] rs, input logic [31:0] pc);
    logic signed [15:0] imm;
    int                 off;
    imm = iw[15:0];
    off = imm;
    case (kind)
      2'd1:    return rs;
      2'd2:    return ((pc + 32'd4) & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
      default: return pc + 32'd4 + 32'(off * 4);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    bus.state = 1'($urandom);
    bus.stall = 1'($urandom);
    @(negedge clk);
    reset     = 1'b0;
    bus.state = 1'b0;
    m_pc      = RV;
    m_active  = 1'b1;
    m_ds      = 1'b0;
    prev_kind = 2'd0;
    #1;
    check("reset_pc", bus.pc, RV);
    check("reset_active", 32'(bus.active), 32'd1);
  endtask

  // One instruction: FETCH cycle, optional stalled EXEC cycles, then the updating EXEC cycle
  task automatic exec_instr(input logic [1:0] kind, input logic [31:0] iw,
                            input logic [31:0] rs, input int nstall);
    logic [31:0] npc;
    @(negedge clk);
    bus.state               = 1'b0;
    bus.stall               = 1'($urandom);
    bus.jump_addr_selection = prev_kind;
    bus.instruction_word    = $urandom;
    bus.rs_data             = $urandom;
    #1 check("fetch_pc", bus.pc, m_pc);
    for (int s = 0; s < nstall; s++) begin
      @(negedge clk);
      bus.state            = 1'b1;
      bus.stall            = 1'b1;
      bus.instruction_word = $urandom;
      bus.rs_data          = $urandom;
      #1 check("stall_pc", bus.pc, m_pc);
    end
    @(negedge clk);
    bus.state            = 1'b1;
    bus.stall            = 1'b0;
    bus.instruction_word = iw;
    bus.rs_data          = rs;
    #1;
    check("exec_pc", bus.pc, m_pc);
    check("exec_pc_plus8", bus.pc_plus8, m_pc + 32'd8);
    check("exec_active", 32'(bus.active), 32'(m_active));
    if (m_active) check("exec_delay_slot", 32'(bus.in_delay_slot), 32'(m_ds));
    @(posedge clk);
    #1;
    if (m_active) begin
      npc = m_ds ? m_tgt : m_pc + 32'd4;
      if (!m_ds && kind != 2'd0) begin
        m_tgt = target_of(kind, iw, rs, m_pc);
        m_ds  = 1'b1;
      end else begin
        m_ds = 1'b0;
      end
      m_pc = npc;
      if (npc == 32'd0) m_active = 1'b0;
    end
    prev_kind = kind;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    bus.state               = 1'b0;
    bus.stall               = 1'b0;
    bus.jump_addr_selection = 2'd0;
    bus.instruction_word    = '0;
    bus.rs_data             = '0;

    // Straight-line sequence
    do_reset();
    for (int i = 0; i < 3; i++) exec_instr(2'd0, NOP, 32'd0, 0);
    check("seq_pc", bus.pc, 32'hBFC0_000C);

    // Taken BEQ forward then backward branch
    do_reset();
    exec_instr(2'd3, {6'b000100, 5'd1, 5'd2, 16'h0003}, 32'd0, 0);
    check("beq_ds_pc", bus.pc, 32'hBFC0_0004);
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("beq_target", bus.pc, 32'hBFC0_0010);
    exec_instr(2'd3, {6'b000100, 5'd1, 5'd2, 16'hFFFC}, 32'd0, 0);
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("back_target", bus.pc, 32'hBFC0_0004);

    // J page-absolute
    do_reset();
    exec_instr(2'd2, {6'b000010, 26'h000_0100}, 32'd0, 0);
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("j_target", bus.pc, 32'hB000_0400);

    // JR to zero halts
    do_reset();
    exec_instr(2'd1, 32'h0000_0008, 32'd0, 0);
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("halt_active", 32'(bus.active), 32'd0);
    for (int i = 0; i < 10; i++) exec_instr(2'($urandom), $urandom, $urandom, 0);
    check("halt_pc", bus.pc, 32'd0);

    // Branch in delay slot of JR is discarded
    do_reset();
    exec_instr(2'd1, 32'h0000_0008, 32'hBFC0_0100, 0);
    exec_instr(2'd3, {6'b000100, 5'd1, 5'd2, 16'h0005}, 32'd0, 0);
    check("jr_target", bus.pc, 32'hBFC0_0100);
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("jr_ds_branch_ignored", bus.pc, 32'hBFC0_0104);

    // Stalled delay slot, then reset cancelling a pending transfer
    do_reset();
    exec_instr(2'd3, {6'b000100, 5'd1, 5'd2, 16'h0003}, 32'd0, 0);
    exec_instr(2'd0, NOP, 32'd0, 3);
    check("stall_target", bus.pc, 32'hBFC0_0010);
    do_reset();
    exec_instr(2'd3, {6'b000100, 5'd1, 5'd2, 16'h0003}, 32'd0, 0);
    do_reset();
    exec_instr(2'd0, NOP, 32'd0, 0);
    check("reset_cancel", bus.pc, RV + 32'd4);

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  kind;
      logic [31:0] rs;
      if ($urandom_range(0, 24) == 0 || (!m_active && $urandom_range(0, 3) == 0)) do_reset();
      kind = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
      rs   = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      exec_instr(kind, $urandom, rs, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
